// File: rtl/user_irq_ctrl.sv
// user_irq_ctrl: synchronizes and qualifies the user-project IRQ lines,
// latches them as level or rising-edge events into a pending register,
// tracks overruns and exposes PEND/MODE/RAW/OVR on the iomem register bus.
//
// Build option: define USER_IRQ_SYNC_EN for a two-flop synchronizer per
// line (asynchronous user IRQs). Left undefined, each line is sampled by a
// single flop and every IRQ latency is one cycle shorter.

// Per-line event logic: input stage, edge detect, pending and overrun bits.
module user_irq_lane (
  input  logic clk,
  input  logic resetn,
  input  logic i_irq,
  input  logic i_ena,
  input  logic i_mode,      // 1 = rising-edge, 0 = level
  input  logic i_clr_pend,  // W1C to PEND for this line
  input  logic i_clr_ovr,   // W1C to OVR for this line
  output logic o_s,
  output logic o_pend,
  output logic o_ovr
);

  logic r_s;
  logic r_prev;
  logic r_pend;
  logic r_ovr;
  logic w_rise;
  logic w_event;

`ifdef USER_IRQ_SYNC_EN
  logic r_meta;

  // Two-flop synchronizer for an IRQ that is asynchronous to clk.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_meta <= 1'b0;
      r_s    <= 1'b0;
    end else begin
      r_meta <= i_irq;
      r_s    <= r_meta;
    end
  end
`else
  // Single sampling flop; the source is assumed synchronous to clk.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_s <= 1'b0;
    else         r_s <= i_irq;
  end
`endif

  assign w_rise  = r_s & ~r_prev;
  assign w_event = i_mode ? w_rise : r_s;

  // Previous synchronized level for edge detection.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_prev <= 1'b0;
    else         r_prev <= r_s;
  end

  // Pending: disable clears, a new event beats a same-cycle W1C.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)         r_pend <= 1'b0;
    else if (!i_ena)     r_pend <= 1'b0;
    else if (w_event)    r_pend <= 1'b1;
    else if (i_clr_pend) r_pend <= 1'b0;
  end

  // Overrun: an edge arriving on an already-pending enabled line; set beats clear.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                               r_ovr <= 1'b0;
    else if (i_ena && i_mode && w_rise && r_pend) r_ovr <= 1'b1;
    else if (i_clr_ovr)                        r_ovr <= 1'b0;
  end

  assign o_s    = r_s;
  assign o_pend = r_pend;
  assign o_ovr  = r_ovr;

endmodule

// Top: register bus, mode register and the array of per-line event lanes.
module user_irq_ctrl #(
  parameter int NUM_LANES = 3
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [31:0]          iomem_addr,
  input  logic                 iomem_valid,
  input  logic [3:0]           iomem_wstrb,
  input  logic [31:0]          iomem_wdata,
  output logic [31:0]          iomem_rdata,
  output logic                 iomem_ready,
  input  logic [NUM_LANES-1:0] user_irq_ena,
  input  logic [NUM_LANES-1:0] user_irq,
  output logic [NUM_LANES-1:0] irq_out,
  output logic                 irq_any
);

  localparam logic [31:0] BASE_ADR = 32'h2F00_0100;
  localparam logic [7:0]  PEND_ADR = 8'h00;
  localparam logic [7:0]  MODE_ADR = 8'h04;
  localparam logic [7:0]  RAW_ADR  = 8'h08;
  localparam logic [7:0]  OVR_ADR  = 8'h0C;

  logic                 r_ready;
  logic [31:0]          r_rdata;
  logic [NUM_LANES-1:0] r_mode;
  logic                 r_any;

  logic                 w_acc;
  logic                 w_wr;
  logic [7:0]           w_off;
  logic [31:0]          w_rd;
  logic [NUM_LANES-1:0] w_s;
  logic [NUM_LANES-1:0] w_pend;
  logic [NUM_LANES-1:0] w_ovr;
  logic [NUM_LANES-1:0] w_clr_pend;
  logic [NUM_LANES-1:0] w_clr_ovr;
  logic                 w_unused;

  // Only byte 0 carries register bits; the rest of the write bus is ignored.
  assign w_unused = &{1'b0, iomem_wdata[31:NUM_LANES], iomem_wstrb[3:1]};

  // Accept a new access only when idle in the ready cycle and addressed here.
  assign w_acc = iomem_valid && !r_ready &&
                 (iomem_addr[31:8] == BASE_ADR[31:8]);
  assign w_off = iomem_addr[7:0];
  assign w_wr  = w_acc && iomem_wstrb[0];

  assign w_clr_pend = (w_wr && (w_off == PEND_ADR)) ? iomem_wdata[NUM_LANES-1:0]
                                                     : '0;
  assign w_clr_ovr  = (w_wr && (w_off == OVR_ADR))  ? iomem_wdata[NUM_LANES-1:0]
                                                     : '0;

  // Read mux uses pre-write state so a read returns the value before any write.
  always_comb begin
    w_rd = '0;
    case (w_off)
      PEND_ADR: w_rd[NUM_LANES-1:0] = w_pend;
      MODE_ADR: w_rd[NUM_LANES-1:0] = r_mode;
      RAW_ADR:  w_rd[NUM_LANES-1:0] = w_s;
      OVR_ADR:  w_rd[NUM_LANES-1:0] = w_ovr;
      default:  w_rd = '0;
    endcase
  end

  // One-cycle ready pulse; read data only reloads on an accepted access.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ready <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ready <= w_acc;
      if (w_acc) r_rdata <= w_rd;
    end
  end

  // Trigger-mode register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                        r_mode <= '0;
    else if (w_wr && (w_off == MODE_ADR)) r_mode <= iomem_wdata[NUM_LANES-1:0];
  end

  // Registered OR of the pending lines.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_any <= 1'b0;
    else         r_any <= |w_pend;
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    user_irq_lane u_lane (
      .clk        (clk),
      .resetn     (resetn),
      .i_irq      (user_irq[g]),
      .i_ena      (user_irq_ena[g]),
      .i_mode     (r_mode[g]),
      .i_clr_pend (w_clr_pend[g]),
      .i_clr_ovr  (w_clr_ovr[g]),
      .o_s        (w_s[g]),
      .o_pend     (w_pend[g]),
      .o_ovr      (w_ovr[g])
    );
  end

  assign iomem_ready = r_ready;
  assign iomem_rdata = r_rdata;
  assign irq_out     = w_pend;
  assign irq_any     = r_any;

endmodule

// File: tb/tb_user_irq_ctrl.sv
// Bench for user_irq_ctrl: directed scenarios plus randomized traffic, all
// checked each cycle against a behavioural model of the register/IRQ rules.
module tb_user_irq_ctrl;

`ifdef USER_IRQ_SYNC_EN
  localparam int SYNC = 2;
`else
  localparam int SYNC = 1;
`endif
  localparam logic [31:0] BASE    = 32'h2F00_0100;
  localparam logic [23:0] BASE_HI = 24'h2F0001;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] addr;
  logic        valid;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic [2:0]  ena;
  logic [2:0]  uirq;
  wire  [31:0] rdata;
  wire         ready;
  wire  [2:0]  irq_out;
  wire         irq_any;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference state: register contents plus a delay line for the input stage.
  logic [2:0]  m_pend, m_mode, m_ovr, m_prev, m_sh0, m_sh1;
  logic        m_any, m_ready;
  logic [31:0] m_rdata;

  user_irq_ctrl dut (
    .clk         (clk),
    .resetn      (resetn),
    .iomem_addr  (addr),
    .iomem_valid (valid),
    .iomem_wstrb (wstrb),
    .iomem_wdata (wdata),
    .iomem_rdata (rdata),
    .iomem_ready (ready),
    .user_irq_ena(ena),
    .user_irq    (uirq),
    .irq_out     (irq_out),
    .irq_any     (irq_any)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic rst_model();
    m_pend = '0; m_mode = '0; m_ovr = '0; m_prev = '0; m_sh0 = '0; m_sh1 = '0;
    m_any = 1'b0; m_ready = 1'b0; m_rdata = '0;
  endtask

  // Advance one clock: predict from the pre-edge inputs, then compare outputs.
  task automatic step();
    logic [2:0]  s, np, no, nm, u;
    logic        acc, wr, rise, ev;
    logic [7:0]  off;
    logic [31:0] rd;
    s   = (SYNC == 2) ? m_sh1 : m_sh0;
    u   = uirq;
    acc = valid && !m_ready && (addr[31:8] == BASE_HI);
    off = addr[7:0];
    wr  = acc && wstrb[0];
    case (off)
      8'h00:   rd = {29'd0, m_pend};
      8'h04:   rd = {29'd0, m_mode};
      8'h08:   rd = {29'd0, s};
      8'h0C:   rd = {29'd0, m_ovr};
      default: rd = 32'd0;
    endcase
    nm = (wr && off == 8'h04) ? wdata[2:0] : m_mode;
    for (int i = 0; i < 3; i++) begin
      rise = s[i] && !m_prev[i];
      ev   = m_mode[i] ? rise : s[i];
      if (!ena[i])                            np[i] = 1'b0;
      else if (ev)                            np[i] = 1'b1;
      else if (wr && off == 8'h00 && wdata[i]) np[i] = 1'b0;
      else                                    np[i] = m_pend[i];
      if (ena[i] && m_mode[i] && rise && m_pend[i]) no[i] = 1'b1;
      else if (wr && off == 8'h0C && wdata[i])      no[i] = 1'b0;
      else                                          no[i] = m_ovr[i];
    end
    @(posedge clk); #1;
    m_any  = |m_pend;
    m_pend = np; m_ovr = no; m_mode = nm; m_prev = s;
    m_sh1  = m_sh0; m_sh0 = u;
    m_ready = acc;
    if (acc) m_rdata = rd;
    chk("irq_out", {29'd0, irq_out}, {29'd0, m_pend});
    chk("irq_any", {31'd0, irq_any}, {31'd0, m_any});
    chk("ready",   {31'd0, ready},   {31'd0, m_ready});
    chk("rdata",   rdata,            m_rdata);
  endtask

  // One complete access: request cycle, then the ready cycle with valid low.
  task automatic bus(input logic [31:0] a, input logic [3:0] st,
                     input logic [31:0] d, output logic [31:0] r);
    addr = a; wstrb = st; wdata = d; valid = 1'b1;
    step();
    r = rdata;
    valid = 1'b0; wstrb = '0;
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  initial begin
    logic [31:0] r;
    resetn = 1'b0; addr = BASE; valid = 1'b0; wstrb = '0; wdata = '0;
    ena = '0; uirq = '0;
    rst_model();
    #1;
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_irq",   {29'd0, irq_out}, 32'd0);
    chk("rst_any",   {31'd0, irq_any}, 32'd0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;

    // Reset contents of every register.
    bus(BASE + 32'h00, 4'h0, 0, r); chk("rst_pend", r, 32'd0);
    bus(BASE + 32'h04, 4'h0, 0, r); chk("rst_mode", r, 32'd0);
    bus(BASE + 32'h08, 4'h0, 0, r); chk("rst_raw",  r, 32'd0);
    bus(BASE + 32'h0C, 4'h0, 0, r); chk("rst_ovr",  r, 32'd0);

    // Level mode, line 1 held high; W1C cannot keep it cleared.
    ena = 3'b111; uirq = 3'b010;
    repeat (3) step();
    chk("lvl_irq", {29'd0, irq_out}, 32'd2);
    bus(BASE + 32'h00, 4'h1, 32'h2, r);
    chk("lvl_reset_irq", {29'd0, irq_out}, 32'd2);
    bus(BASE + 32'h00, 4'h0, 0, r); chk("lvl_pend", r, 32'd2);

    // Edge mode on line 0, two pulses without clearing -> overrun.
    bus(BASE + 32'h04, 4'h1, 32'h1, r);
    ena = 3'b001; uirq = 3'b000;
    repeat (4) step();
    repeat (2) begin
      uirq = 3'b001; step();
      uirq = 3'b000; repeat (3) step();
    end
    bus(BASE + 32'h00, 4'h0, 0, r); chk("ovr_pend", r, 32'd1);
    bus(BASE + 32'h0C, 4'h0, 0, r); chk("ovr_ovr",  r, 32'd1);
    bus(BASE + 32'h0C, 4'h1, 32'h1, r);
    bus(BASE + 32'h00, 4'h1, 32'h1, r);
    bus(BASE + 32'h00, 4'h0, 0, r); chk("clr_pend", r, 32'd0);
    bus(BASE + 32'h0C, 4'h0, 0, r); chk("clr_ovr",  r, 32'd0);

    // Disabled lines: RAW tracks, PEND stays clear; enabling a high level line.
    ena = 3'b000; uirq = 3'b111;
    repeat (3) step();
    bus(BASE + 32'h08, 4'h0, 0, r); chk("dis_raw7",  r, 32'd7);
    bus(BASE + 32'h00, 4'h0, 0, r); chk("dis_pend7", r, 32'd0);
    uirq = 3'b101;
    repeat (3) step();
    bus(BASE + 32'h08, 4'h0, 0, r); chk("dis_raw5",  r, 32'd5);
    bus(BASE + 32'h00, 4'h0, 0, r); chk("dis_pend5", r, 32'd0);
    bus(BASE + 32'h04, 4'h1, 32'h0, r);
    ena = 3'b100;
    step();
    chk("ena_irq2", {29'd0, irq_out}, 32'd4);

    // Edge event landing on the same edge as a W1C to PEND.
    bus(BASE + 32'h04, 4'h1, 32'h7, r);
    ena = 3'b111; uirq = 3'b000;
    repeat (4) step();
    bus(BASE + 32'h00, 4'h1, 32'h7, r);
    bus(BASE + 32'h00, 4'h0, 0, r); chk("race_pre", r, 32'd0);
    uirq = 3'b001;
    for (int k = 0; k < SYNC; k++) step();
    bus(BASE + 32'h00, 4'h1, 32'h1, r);
    bus(BASE + 32'h00, 4'h0, 0, r); chk("race_pend", r, 32'd1);

    // Unmapped offset in the block, then an address outside it.
    addr = BASE + 32'h20; wstrb = 4'hF; wdata = 32'hFFFF_FFFF; valid = 1'b1;
    step();
    chk("odd_rdy1", {31'd0, ready}, 32'd1);
    chk("odd_rd",   rdata, 32'd0);
    valid = 1'b0; wstrb = '0;
    step();
    chk("odd_rdy0", {31'd0, ready}, 32'd0);
    addr = 32'h2F00_0200; valid = 1'b1;
    repeat (5) begin
      step();
      chk("miss_rdy", {31'd0, ready}, 32'd0);
    end
    valid = 1'b0;

    // Reset asserted in the middle of an access.
    addr = BASE + 32'h04; wstrb = 4'h0; valid = 1'b1;
    #3 resetn = 1'b0;
    #1;
    chk("mrst_ready", {31'd0, ready}, 32'd0);
    chk("mrst_rdata", rdata, 32'd0);
    chk("mrst_irq",   {29'd0, irq_out}, 32'd0);
    chk("mrst_any",   {31'd0, irq_any}, 32'd0);
    rst_model();
    @(posedge clk); #1;
    chk("mrst_hold", {31'd0, ready}, 32'd0);
    resetn = 1'b1;
    step();

    // Randomized traffic against the model.
    for (int n = 0; n < 800; n++) begin
      valid = ($urandom_range(0, 1) == 1);
      case ($urandom_range(0, 6))
        0:       addr = BASE + 32'h00;
        1:       addr = BASE + 32'h04;
        2:       addr = BASE + 32'h08;
        3:       addr = BASE + 32'h0C;
        4:       addr = BASE + 32'h10;
        5:       addr = 32'h2F00_0200;
        default: addr = BASE + 32'h00;
      endcase
      wstrb = 4'($urandom_range(0, 15));
      wdata = $urandom;
      if ($urandom_range(0, 15) == 0) ena = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0)  uirq = 3'($urandom_range(0, 7));
      step();
    end
    valid = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
